// File: rtl/dvi_fb_apb_flip_master.sv
`default_nettype none
// ============================================================================
// Module   : dvi_fb_apb_flip_master
// Brief    : APB initiator for the DVI framebuffer register port. Performs a
//            reset-time CONFIG write, then serves frame flips and host accesses.
// Revision : 1.0 - initial release
// ============================================================================
module dvi_fb_apb_flip_master #(
  parameter logic [31:0] INIT_CONFIG    = 32'h0000_0005,
  parameter bit          INIT_ENABLE    = 1'b1,
  parameter int          PREADY_TIMEOUT = 16,
  parameter int          POLL_GAP       = 8
) (
  input  logic        cfg_clk_i,
  input  logic        cfg_nrst_i,
  output logic [11:0] cfg_paddr_o,
  output logic        cfg_psel_o,
  output logic        cfg_penable_o,
  output logic        cfg_pwrite_o,
  output logic [31:0] cfg_pwdata_o,
  input  logic [31:0] cfg_prdata_i,
  input  logic        cfg_pready_i,
  input  logic        flip_req_i,
  input  logic [31:0] flip_base_i,
  output logic        flip_busy_o,
  output logic        flip_done_o,
  output logic        flip_err_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [11:0] host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_ack_o,
  output logic [31:0] host_rdata_o,
  output logic        host_err_o,
  output logic        init_done_o
);

  localparam int c_TO_W  = $clog2(PREADY_TIMEOUT + 1);
  localparam int c_GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(PREADY_TIMEOUT - 1);
  localparam logic [c_TO_W-1:0]  c_TO_ONE   = c_TO_W'(1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(POLL_GAP - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
  localparam logic [11:0] c_ADDR_CONFIG = 12'h000;
  localparam logic [11:0] c_ADDR_STATUS = 12'h004;
  localparam logic [11:0] c_ADDR_FBUF   = 12'h008;
  localparam logic [31:0] c_ERR_DATA    = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_FLIP_WR  = 3'd2,
    S_POLL_RD  = 3'd3,
    S_POLL_GAP = 3'd4,
    S_HOST     = 3'd5
  } seq_t;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_SETUP  = 2'd1,
    A_ACCESS = 2'd2,
    A_GAP    = 2'd3
  } apb_t;

  seq_t               r_seq;
  apb_t               r_apb;
  logic [c_TO_W-1:0]  r_to_cnt;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic [15:0]        r_baseline;
  logic               r_have_base;
  logic [11:0]        r_paddr;
  logic               r_psel;
  logic               r_penable;
  logic               r_pwrite;
  logic [31:0]        r_pwdata;
  logic               r_flip_busy;
  logic               r_flip_done;
  logic               r_flip_err;
  logic               r_host_ack;
  logic               r_host_err;
  logic [31:0]        r_host_rdata;
  logic               r_init_done;

  logic        w_idle_ok;
  logic        w_flip_ok;
  logic        w_take_flip;
  logic        w_flip_bad;
  logic        w_take_host;
  logic        w_timeout;
  logic        w_end;
  logic [15:0] w_v;
  logic        w_launch;
  logic [11:0] w_l_addr;
  logic        w_l_we;
  logic [31:0] w_l_wdata;

  assign w_idle_ok   = (r_seq == S_IDLE) && r_init_done && (r_apb == A_IDLE);
  assign w_flip_ok   = (flip_base_i[6:0] == 7'd0);
  assign w_take_flip = w_idle_ok && flip_req_i && w_flip_ok;
  assign w_flip_bad  = w_idle_ok && flip_req_i && !w_flip_ok;
  assign w_take_host = w_idle_ok && !flip_req_i && host_req_i;
  assign w_timeout   = (r_apb == A_ACCESS) && !cfg_pready_i && (r_to_cnt == c_TO_LAST);
  assign w_end       = (r_apb == A_ACCESS) && (cfg_pready_i || w_timeout);
  assign w_v         = cfg_prdata_i[31:16];

  // Next transfer to launch; only honoured while the APB side is idle.
  always_comb begin
    w_launch  = 1'b0;
    w_l_addr  = 12'h000;
    w_l_we    = 1'b0;
    w_l_wdata = 32'h0;
    if (r_seq == S_INIT && INIT_ENABLE && r_apb == A_IDLE) begin
      w_launch  = 1'b1;
      w_l_addr  = c_ADDR_CONFIG;
      w_l_we    = 1'b1;
      w_l_wdata = INIT_CONFIG;
    end else if (r_seq == S_POLL_RD && r_apb == A_IDLE) begin
      w_launch  = 1'b1;
      w_l_addr  = c_ADDR_STATUS;
    end else if (w_take_flip) begin
      w_launch  = 1'b1;
      w_l_addr  = c_ADDR_FBUF;
      w_l_we    = 1'b1;
      w_l_wdata = {7'd0, flip_base_i[31:7]};
    end else if (w_take_host) begin
      w_launch  = 1'b1;
      w_l_addr  = host_addr_i;
      w_l_we    = host_we_i;
      w_l_wdata = host_wdata_i;
    end
  end

  always_ff @(posedge cfg_clk_i or negedge cfg_nrst_i) begin
    if (!cfg_nrst_i) begin
      r_seq        <= S_INIT;
      r_apb        <= A_IDLE;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_baseline   <= 16'h0;
      r_have_base  <= 1'b0;
      r_paddr      <= 12'h000;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= 32'h0;
      r_flip_busy  <= 1'b0;
      r_flip_done  <= 1'b0;
      r_flip_err   <= 1'b0;
      r_host_ack   <= 1'b0;
      r_host_err   <= 1'b0;
      r_host_rdata <= 32'h0;
      r_init_done  <= 1'b0;
    end else begin
      r_flip_done <= 1'b0;
      r_flip_err  <= 1'b0;
      r_host_ack  <= 1'b0;
      r_host_err  <= 1'b0;

      // The A_GAP cycle keeps the slave's registered pready from bleeding
      // into the next transfer.
      case (r_apb)
        A_IDLE: begin
          if (w_launch) begin
            r_apb     <= A_SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= w_l_addr;
            r_pwrite  <= w_l_we;
            r_pwdata  <= w_l_wdata;
          end
        end
        A_SETUP: begin
          r_apb     <= A_ACCESS;
          r_penable <= 1'b1;
          r_to_cnt  <= '0;
        end
        A_ACCESS: begin
          if (w_end) begin
            r_apb     <= A_GAP;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
          end
        end
        default: r_apb <= A_IDLE;
      endcase

      case (r_seq)
        S_INIT: begin
          if (!INIT_ENABLE || w_end) begin
            r_init_done <= 1'b1;
            r_seq       <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_take_flip) begin
            r_seq       <= S_FLIP_WR;
            r_flip_busy <= 1'b1;
            r_have_base <= 1'b0;
          end else if (w_flip_bad) begin
            r_flip_err <= 1'b1;
          end else if (w_take_host) begin
            r_seq <= S_HOST;
          end
        end
        S_FLIP_WR: begin
          if (w_end) begin
            if (w_timeout) begin
              r_flip_err  <= 1'b1;
              r_flip_busy <= 1'b0;
              r_seq       <= S_IDLE;
            end else begin
              r_seq <= S_POLL_RD;
            end
          end
        end
        S_POLL_RD: begin
          if (w_end) begin
            if (w_timeout) begin
              r_flip_err  <= 1'b1;
              r_flip_busy <= 1'b0;
              r_seq       <= S_IDLE;
            end else if (r_have_base && (w_v < r_baseline)) begin
              // Scan-out line counter went backwards: new frame started.
              r_flip_done <= 1'b1;
              r_flip_busy <= 1'b0;
              r_seq       <= S_IDLE;
            end else begin
              r_baseline  <= w_v;
              r_have_base <= 1'b1;
              r_gap_cnt   <= '0;
              r_seq       <= S_POLL_GAP;
            end
          end
        end
        S_POLL_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_seq <= S_POLL_RD;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
          end
        end
        S_HOST: begin
          if (w_end) begin
            r_host_ack <= 1'b1;
            r_seq      <= S_IDLE;
            if (w_timeout) begin
              r_host_err   <= 1'b1;
              r_host_rdata <= c_ERR_DATA;
            end else if (!r_pwrite) begin
              r_host_rdata <= cfg_prdata_i;
            end
          end
        end
        default: r_seq <= S_INIT;
      endcase
    end
  end

  assign cfg_paddr_o   = r_paddr;
  assign cfg_psel_o    = r_psel;
  assign cfg_penable_o = r_penable;
  assign cfg_pwrite_o  = r_pwrite;
  assign cfg_pwdata_o  = r_pwdata;
  assign flip_busy_o   = r_flip_busy;
  assign flip_done_o   = r_flip_done;
  assign flip_err_o    = r_flip_err;
  assign host_ack_o    = r_host_ack;
  assign host_err_o    = r_host_err;
  assign host_rdata_o  = r_host_rdata;
  assign init_done_o   = r_init_done;

endmodule
`default_nettype wire
